// File: rtl/vga_clock_pkg.sv
// Shared widths, BCD limits, button FSM states and the BCD increment helper.
package vga_clock_pkg;

   localparam int unsigned CLK_HZ_DEFAULT       = 31_500_000;
   localparam int unsigned DEBOUNCE_CYC_DEFAULT = 65_536;
   localparam int unsigned HOLD_CYC_DEFAULT     = 15_750_000;
   localparam int unsigned REPEAT_CYC_DEFAULT   = 3_150_000;

   localparam int unsigned BCD_W    = 4;
   localparam int unsigned HRS_D1_W = 2;
   localparam int unsigned MIN_D1_W = 3;
   localparam int unsigned SEC_D1_W = 3;

   typedef logic [7:0] bcd2_t;

   localparam bcd2_t SEC_MAX = 8'h59;
   localparam bcd2_t MIN_MAX = 8'h59;
   localparam bcd2_t HRS_MAX = 8'h23;

   typedef struct packed {
      bcd2_t hrs;
      bcd2_t min;
      bcd2_t sec;
   } bcd_time_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_REPEAT
   } btn_state_e;

   // Two-digit BCD increment that wraps to 00 after vmax.
   function automatic bcd2_t bcd_inc(input bcd2_t v, input bcd2_t vmax);
      bcd2_t r;
      if (v == vmax) begin
         r = '0;
      end else if (v[3:0] == 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

endpackage

// File: rtl/vga_clock_timekeeper_if.sv
// Button inputs and BCD time outputs between the timekeeper and the display side.
interface vga_clock_timekeeper_if
   import vga_clock_pkg::*;
;
   logic                adj_hrs;
   logic                adj_min;
   logic                adj_sec;
   logic [HRS_D1_W-1:0] hrs_d1;
   logic [BCD_W-1:0]    hrs_d0;
   logic [MIN_D1_W-1:0] min_d1;
   logic [BCD_W-1:0]    min_d0;
   logic [SEC_D1_W-1:0] sec_d1;
   logic [BCD_W-1:0]    sec_d0;
   logic                sec_tick;
   logic                time_upd;

   modport master (
      output adj_hrs, adj_min, adj_sec,
      input  hrs_d1, hrs_d0, min_d1, min_d0, sec_d1, sec_d0, sec_tick, time_upd
   );

   modport slave (
      input  adj_hrs, adj_min, adj_sec,
      output hrs_d1, hrs_d0, min_d1, min_d0, sec_d1, sec_d0, sec_tick, time_upd
   );
endinterface

// File: rtl/btn_debounce_repeat.sv
// Synchronise, debounce and auto-repeat one adjust button into one-cycle inc pulses.
module btn_debounce_repeat
   import vga_clock_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
   parameter int unsigned HOLD_CYC     = HOLD_CYC_DEFAULT,
   parameter int unsigned REPEAT_CYC   = REPEAT_CYC_DEFAULT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_raw,
   output logic inc
);

   localparam int unsigned DW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int unsigned MAXC = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
   localparam int unsigned RW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   logic          sync1_q, sync2_q, lvl_prev_q;
   logic [DW-1:0] db_q, db_d;
   logic          acc_q, acc_d;
   btn_state_e    st_q, st_d;
   logic [RW-1:0] rc_q, rc_d;
   logic          inc_q, inc_d;

   // Two-flop synchroniser plus previous synchronised level for change detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         lvl_prev_q <= 1'b0;
      end else begin
         sync1_q    <= btn_raw;
         sync2_q    <= sync1_q;
         lvl_prev_q <= sync2_q;
      end
   end

   // Debounce: any level change restarts the count; a full stable count accepts the level.
   always_comb begin
      db_d  = db_q;
      acc_d = acc_q;
      if (sync2_q != lvl_prev_q) begin
         db_d = '0;
      end else if (db_q == DW'(DEBOUNCE_CYC - 1)) begin
         acc_d = lvl_prev_q;
      end else begin
         db_d = db_q + DW'(1);
      end
   end

   // Press / hold / repeat sequencing on the accepted level.
   always_comb begin
      st_d  = st_q;
      rc_d  = rc_q;
      inc_d = 1'b0;
      case (st_q)
         ST_IDLE: begin
            if (acc_q) begin
               st_d  = ST_HOLD;
               rc_d  = '0;
               inc_d = 1'b1;
            end
         end
         ST_HOLD: begin
            if (!acc_q) begin
               st_d = ST_IDLE;
               rc_d = '0;
            end else if (rc_q == RW'(HOLD_CYC - 1)) begin
               st_d  = ST_REPEAT;
               rc_d  = '0;
               inc_d = 1'b1;
            end else begin
               rc_d = rc_q + RW'(1);
            end
         end
         ST_REPEAT: begin
            if (!acc_q) begin
               st_d = ST_IDLE;
               rc_d = '0;
            end else if (rc_q == RW'(REPEAT_CYC - 1)) begin
               rc_d  = '0;
               inc_d = 1'b1;
            end else begin
               rc_d = rc_q + RW'(1);
            end
         end
         default: begin
            st_d = ST_IDLE;
            rc_d = '0;
         end
      endcase
   end

   // Debounce and FSM state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         db_q  <= '0;
         acc_q <= 1'b0;
         st_q  <= ST_IDLE;
         rc_q  <= '0;
         inc_q <= 1'b0;
      end else begin
         db_q  <= db_d;
         acc_q <= acc_d;
         st_q  <= st_d;
         rc_q  <= rc_d;
         inc_q <= inc_d;
      end
   end

   assign inc = inc_q;

endmodule

// File: rtl/vga_clock_timekeeper.sv
// 24 h BCD timekeeper: 1 s prescaler, button-driven field adjust, deferred tick on collision.
module vga_clock_timekeeper
   import vga_clock_pkg::*;
#(
   parameter int unsigned CLK_HZ       = CLK_HZ_DEFAULT,
   parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
   parameter int unsigned HOLD_CYC     = HOLD_CYC_DEFAULT,
   parameter int unsigned REPEAT_CYC   = REPEAT_CYC_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset_n,
   vga_clock_timekeeper_if.slave bus
);

   localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   logic          inc_hrs, inc_min, inc_sec;
   logic          any_inc_c, tick_eff_c;
   logic [PW-1:0] pre_q, pre_d;
   logic          tick_q, tick_d;
   bcd_time_t     time_q, time_d;
   logic          pend_q, pend_d;
   logic          chg_q, chg_d;
   logic          upd_q;

   btn_debounce_repeat #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)
   ) u_btn_hrs (.clk(clk), .reset_n(reset_n), .btn_raw(bus.adj_hrs), .inc(inc_hrs));

   btn_debounce_repeat #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)
   ) u_btn_min (.clk(clk), .reset_n(reset_n), .btn_raw(bus.adj_min), .inc(inc_min));

   btn_debounce_repeat #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)
   ) u_btn_sec (.clk(clk), .reset_n(reset_n), .btn_raw(bus.adj_sec), .inc(inc_sec));

   assign any_inc_c  = inc_hrs | inc_min | inc_sec;
   assign tick_eff_c = tick_q | pend_q;

   // Prescaler; tick register is high exactly while the count holds CLK_HZ-1.
   always_comb begin
      pre_d  = (pre_q == PW'(CLK_HZ - 1)) ? '0 : pre_q + PW'(1);
      tick_d = (pre_d == PW'(CLK_HZ - 1));
   end

   // Field update: adjusts win the cycle and defer a coincident tick by one free cycle.
   always_comb begin
      time_d = time_q;
      pend_d = pend_q;
      if (any_inc_c) begin
         if (inc_sec) time_d.sec = bcd_inc(time_q.sec, SEC_MAX);
         if (inc_min) time_d.min = bcd_inc(time_q.min, MIN_MAX);
         if (inc_hrs) time_d.hrs = bcd_inc(time_q.hrs, HRS_MAX);
         pend_d = tick_eff_c;
      end else if (tick_eff_c) begin
         time_d.sec = bcd_inc(time_q.sec, SEC_MAX);
         if (time_q.sec == SEC_MAX) begin
            time_d.min = bcd_inc(time_q.min, MIN_MAX);
            if (time_q.min == MIN_MAX) begin
               time_d.hrs = bcd_inc(time_q.hrs, HRS_MAX);
            end
         end
         pend_d = 1'b0;
      end
      chg_d = (time_d != time_q);
   end

   // Time, prescaler and update-strobe registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_q  <= '0;
         tick_q <= 1'b0;
         time_q <= '0;
         pend_q <= 1'b0;
         chg_q  <= 1'b0;
         upd_q  <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         tick_q <= tick_d;
         time_q <= time_d;
         pend_q <= pend_d;
         chg_q  <= chg_d;
         upd_q  <= chg_q;
      end
   end

   assign bus.hrs_d1   = time_q.hrs[BCD_W +: HRS_D1_W];
   assign bus.hrs_d0   = time_q.hrs[BCD_W-1:0];
   assign bus.min_d1   = time_q.min[BCD_W +: MIN_D1_W];
   assign bus.min_d0   = time_q.min[BCD_W-1:0];
   assign bus.sec_d1   = time_q.sec[BCD_W +: SEC_D1_W];
   assign bus.sec_d0   = time_q.sec[BCD_W-1:0];
   assign bus.sec_tick = tick_q;
   assign bus.time_upd = upd_q;

endmodule

// File: tb/tb_vga_clock_timekeeper.sv
// Directed bench for the VGA clock timekeeper with shortened timing parameters.
module tb_vga_clock_timekeeper;

   logic clk;
   logic reset_n;
   int   n_pass;
   int   n_total;

   vga_clock_timekeeper_if bus ();

   vga_clock_timekeeper #(
      .CLK_HZ(10), .DEBOUNCE_CYC(4), .HOLD_CYC(20), .REPEAT_CYC(8)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [23:0] cur_time();
      return {2'b00, bus.hrs_d1, bus.hrs_d0, 1'b0, bus.min_d1, bus.min_d0,
              1'b0, bus.sec_d1, bus.sec_d0};
   endfunction

   function automatic logic [7:0] hrs_v();
      return {2'b00, bus.hrs_d1, bus.hrs_d0};
   endfunction

   function automatic logic [7:0] min_v();
      return {1'b0, bus.min_d1, bus.min_d0};
   endfunction

   function automatic logic [7:0] sec_v();
      return {1'b0, bus.sec_d1, bus.sec_d0};
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      bus.adj_hrs = 1'b0;
      bus.adj_min = 1'b0;
      bus.adj_sec = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Hold hrs/min buttons; release each 3 cycles after its field shows stop value.
   task automatic set_fields(input logic hold_h, input logic [7:0] stop_h,
                             input logic hold_m, input logic [7:0] stop_m,
                             output logic ok);
      int rel_h;
      int rel_m;
      rel_h = hold_h ? -1 : 0;
      rel_m = hold_m ? -1 : 0;
      bus.adj_hrs = hold_h;
      bus.adj_min = hold_m;
      ok = 1'b0;
      for (int i = 0; i < 700 && !ok; i++) begin
         cyc(1);
         if (rel_h > 0) begin
            rel_h--;
            if (rel_h == 0) bus.adj_hrs = 1'b0;
         end else if (rel_h < 0 && hrs_v() == stop_h) begin
            rel_h = 3;
         end
         if (rel_m > 0) begin
            rel_m--;
            if (rel_m == 0) bus.adj_min = 1'b0;
         end else if (rel_m < 0 && min_v() == stop_m) begin
            rel_m = 3;
         end
         ok = (rel_h == 0) && (rel_m == 0);
      end
      bus.adj_hrs = 1'b0;
      bus.adj_min = 1'b0;
      cyc(20);
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      n_total++;
      if (cur_time() !== 24'h000000) $display("FAIL reset_time: got %h expected 000000", cur_time());
      else n_pass++;
      n_total++;
      if (bus.sec_tick !== 1'b0) $display("FAIL reset_tick: got %b expected 0", bus.sec_tick);
      else n_pass++;
      n_total++;
      if (bus.time_upd !== 1'b0) $display("FAIL reset_upd: got %b expected 0", bus.time_upd);
      else n_pass++;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_first_second();
      int n_tick, n_upd, tick_at;
      n_tick = 0; n_upd = 0; tick_at = -1;
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         cyc(1);
         if (bus.sec_tick === 1'b1) begin n_tick++; tick_at = k; end
         if (bus.time_upd === 1'b1) n_upd++;
      end
      n_total++;
      if (n_tick != 1) $display("FAIL first_tick_count: got %0d expected 1", n_tick);
      else n_pass++;
      n_total++;
      if (tick_at != 9) $display("FAIL first_tick_cycle: got %0d expected 9", tick_at);
      else n_pass++;
      n_total++;
      if (n_upd != 1) $display("FAIL first_upd_count: got %0d expected 1", n_upd);
      else n_pass++;
      n_total++;
      if (cur_time() !== 24'h000001) $display("FAIL first_time: got %h expected 000001", cur_time());
      else n_pass++;
   endtask

   task automatic test_midnight_wrap();
      logic        ok;
      logic        found;
      logic [23:0] prev;
      int          n_upd, n_chg;
      do_reset();
      set_fields(1'b1, 8'h22, 1'b1, 8'h58, ok);
      n_total++;
      if (ok !== 1'b1) $display("FAIL wrap_setup_done: got %b expected 1", ok);
      else n_pass++;
      n_total++;
      if (hrs_v() !== 8'h23) $display("FAIL wrap_setup_hrs: got %h expected 23", hrs_v());
      else n_pass++;
      n_total++;
      if (min_v() !== 8'h59) $display("FAIL wrap_setup_min: got %h expected 59", min_v());
      else n_pass++;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (sec_v() == 8'h59) found = 1'b1;
         else cyc(1);
      end
      n_total++;
      if (!found || cur_time() !== 24'h235959)
         $display("FAIL wrap_reach_235959: got %h expected 235959", cur_time());
      else n_pass++;
      cyc(2);
      prev = cur_time();
      n_upd = 0; n_chg = 0;
      for (int k = 0; k < 12; k++) begin
         cyc(1);
         if (bus.time_upd === 1'b1) n_upd++;
         if (cur_time() !== prev) n_chg++;
         prev = cur_time();
      end
      n_total++;
      if (cur_time() !== 24'h000000) $display("FAIL wrap_time: got %h expected 000000", cur_time());
      else n_pass++;
      n_total++;
      if (n_chg != 1) $display("FAIL wrap_changes: got %0d expected 1", n_chg);
      else n_pass++;
      n_total++;
      if (n_upd != 1) $display("FAIL wrap_upd_count: got %0d expected 1", n_upd);
      else n_pass++;
   endtask

   task automatic test_bounce_min();
      logic       ok;
      logic [7:0] prev;
      int         n_chg;
      do_reset();
      set_fields(1'b0, 8'h00, 1'b1, 8'h58, ok);
      n_total++;
      if (ok !== 1'b1 || min_v() !== 8'h59)
         $display("FAIL bounce_setup_min: got %h expected 59", min_v());
      else n_pass++;
      prev = min_v();
      n_chg = 0;
      for (int i = 0; i < 52; i++) begin
         if (i < 20) bus.adj_min = i[1];
         else if (i < 32) bus.adj_min = 1'b1;
         else bus.adj_min = 1'b0;
         cyc(1);
         if (min_v() !== prev) n_chg++;
         prev = min_v();
      end
      n_total++;
      if (n_chg != 1) $display("FAIL bounce_min_incs: got %0d expected 1", n_chg);
      else n_pass++;
      n_total++;
      if (min_v() !== 8'h00) $display("FAIL bounce_min_wrap: got %h expected 00", min_v());
      else n_pass++;
      n_total++;
      if (hrs_v() !== 8'h00) $display("FAIL bounce_hrs_kept: got %h expected 00", hrs_v());
      else n_pass++;
   endtask

   task automatic test_auto_repeat();
      int         exp_t [6];
      int         chg_t [$];
      logic       found;
      logic [7:0] prev;
      exp_t = '{0, 20, 28, 36, 44, 52};
      do_reset();
      bus.adj_hrs = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         cyc(1);
         if (hrs_v() != 8'h00) found = 1'b1;
      end
      n_total++;
      if (!found) $display("FAIL repeat_first_press: got %h expected 01", hrs_v());
      else n_pass++;
      chg_t.push_back(0);
      prev = hrs_v();
      for (int k = 1; k <= 90; k++) begin
         cyc(1);
         if (hrs_v() !== prev) chg_t.push_back(k);
         prev = hrs_v();
         if (k == 47) bus.adj_hrs = 1'b0;
      end
      n_total++;
      if (chg_t.size() != 6) $display("FAIL repeat_count: got %0d expected 6", chg_t.size());
      else n_pass++;
      n_total++;
      if (hrs_v() !== 8'h06) $display("FAIL repeat_hrs: got %h expected 06", hrs_v());
      else n_pass++;
      for (int i = 1; i < 6; i++) begin
         n_total++;
         if (i >= chg_t.size()) $display("FAIL repeat_time_%0d: got none expected %0d", i, exp_t[i]);
         else if (chg_t[i] != exp_t[i])
            $display("FAIL repeat_time_%0d: got %0d expected %0d", i, chg_t[i], exp_t[i]);
         else n_pass++;
      end
   endtask

   task automatic test_tick_collision();
      logic found;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 150 && !found; i++) begin
         cyc(1);
         if (sec_v() == 8'h10) found = 1'b1;
      end
      n_total++;
      if (!found) $display("FAIL coll_reach_10: got %h expected 10", sec_v());
      else n_pass++;
      cyc(1);
      bus.adj_sec = 1'b1;
      cyc(8);
      n_total++;
      if (bus.sec_tick !== 1'b1 || sec_v() !== 8'h10)
         $display("FAIL coll_align: got tick=%b sec=%h expected tick=1 sec=10", bus.sec_tick, sec_v());
      else n_pass++;
      cyc(1);
      n_total++;
      if (sec_v() !== 8'h11) $display("FAIL coll_inc: got %h expected 11", sec_v());
      else n_pass++;
      cyc(1);
      bus.adj_sec = 1'b0;
      n_total++;
      if (sec_v() !== 8'h12) $display("FAIL coll_pend_tick: got %h expected 12", sec_v());
      else n_pass++;
      cyc(1);
      n_total++;
      if (sec_v() !== 8'h12) $display("FAIL coll_no_double: got %h expected 12", sec_v());
      else n_pass++;
      cyc(8);
      n_total++;
      if (sec_v() !== 8'h13) $display("FAIL coll_next_tick: got %h expected 13", sec_v());
      else n_pass++;
      n_total++;
      if (cur_time() !== 24'h000013) $display("FAIL coll_time: got %h expected 000013", cur_time());
      else n_pass++;
   endtask

   task automatic test_reset_mid_repeat();
      do_reset();
      bus.adj_hrs = 1'b1;
      cyc(40);
      n_total++;
      if (hrs_v() !== 8'h03) $display("FAIL midrst_pre_hrs: got %h expected 03", hrs_v());
      else n_pass++;
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      n_total++;
      if (cur_time() !== 24'h000000) $display("FAIL midrst_time: got %h expected 000000", cur_time());
      else n_pass++;
      n_total++;
      if (bus.sec_tick !== 1'b0) $display("FAIL midrst_tick: got %b expected 0", bus.sec_tick);
      else n_pass++;
      n_total++;
      if (bus.time_upd !== 1'b0) $display("FAIL midrst_upd: got %b expected 0", bus.time_upd);
      else n_pass++;
      bus.adj_hrs = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      cyc(40);
      n_total++;
      if (hrs_v() !== 8'h00) $display("FAIL midrst_no_inc: got %h expected 00", hrs_v());
      else n_pass++;
      bus.adj_hrs = 1'b1;
      cyc(12);
      bus.adj_hrs = 1'b0;
      cyc(15);
      n_total++;
      if (hrs_v() !== 8'h01) $display("FAIL midrst_new_press: got %h expected 01", hrs_v());
      else n_pass++;
   endtask

   task automatic test_hold_through_reset();
      bus.adj_hrs = 1'b1;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      cyc(15);
      bus.adj_hrs = 1'b0;
      cyc(20);
      n_total++;
      if (hrs_v() !== 8'h01) $display("FAIL held_reset_press: got %h expected 01", hrs_v());
      else n_pass++;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      reset_n = 1'b1;
      bus.adj_hrs = 1'b0;
      bus.adj_min = 1'b0;
      bus.adj_sec = 1'b0;
      test_reset();
      test_first_second();
      test_midnight_wrap();
      test_bounce_min();
      test_auto_repeat();
      test_tick_collision();
      test_reset_mid_repeat();
      test_hold_through_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
